// File: rtl/ultrasonido_ranger.sv
// ultrasonido_ranger: HC-SR04 trigger/echo engine reporting the echo width in whole centimetres
module ultrasonido_ranger #(
  parameter int TRIG_CYCLES    = 250,
  parameter int CM_CYCLES      = 1450,
  parameter int TIMEOUT_CYCLES = 950000,
  parameter int HOLDOFF_CYCLES = 1500000,
  parameter int DIST_W         = 9
) (
  input  logic              CLKOUT2,
  input  logic              reset,
  input  logic              ENABLE,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);
  localparam int MAX_A = TRIG_CYCLES > TIMEOUT_CYCLES ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C = MAX_A > HOLDOFF_CYCLES ? MAX_A : HOLDOFF_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  localparam int SW = $clog2(CM_CYCLES + 1);
  localparam logic [CW-1:0] TRIG_END = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HO_END   = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [SW-1:0] SUB_END  = SW'(CM_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t state, nxt;
  logic echo_m, echo_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] sub, sub_nxt;
  logic [DIST_W-1:0] cm, cm_nxt, cm_inc;
  logic rep, rep_to;

  // two-flop synchronizer for the asynchronous echo pin
  always_ff @(posedge CLKOUT2 or negedge reset)
    if (!reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end

  // next state, counters and report request; a low ENABLE overrides everything
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + 1'b1;
    sub_nxt = sub;
    cm_nxt  = cm;
    rep     = 1'b0;
    rep_to  = 1'b0;
    cm_inc  = (sub == SUB_END && cm != '1) ? cm + 1'b1 : cm;
    if (!ENABLE) begin
      nxt     = IDLE;
      cnt_nxt = '0;
    end else
      case (state)
        IDLE: begin
          nxt     = TRIG;
          cnt_nxt = '0;
        end
        TRIG: if (cnt == TRIG_END) begin
          nxt     = WAIT_RISE;
          cnt_nxt = '0;
        end
        WAIT_RISE: if (echo_s) begin
          nxt     = MEASURE;
          cnt_nxt = '0;
          sub_nxt = '0;
          cm_nxt  = '0;
        end else if (cnt == TO_END) begin
          nxt     = HOLDOFF;
          cnt_nxt = '0;
          rep     = 1'b1;
          rep_to  = 1'b1;
        end
        MEASURE: begin
          sub_nxt = sub == SUB_END ? '0 : sub + 1'b1;
          cm_nxt  = cm_inc;
          if (!echo_s || cnt == TO_END) begin
            nxt     = HOLDOFF;
            cnt_nxt = '0;
            rep     = 1'b1;
            rep_to  = echo_s;
          end
        end
        HOLDOFF: if (cnt == HO_END) begin
          nxt     = TRIG;
          cnt_nxt = '0;
        end
        default: nxt = IDLE;
      endcase
  end

  // state and counter registers
  always_ff @(posedge CLKOUT2 or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sub   <= '0;
      cm    <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      sub   <= sub_nxt;
      cm    <= cm_nxt;
    end

  // registered outputs; the result includes the count of the cycle the echo is seen low
  always_ff @(posedge CLKOUT2 or negedge reset)
    if (!reset) begin
      trigger  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      distance <= '0;
      timeout  <= 1'b0;
    end else begin
      trigger  <= nxt == TRIG;
      busy     <= nxt != IDLE;
      valid    <= rep;
      distance <= rep ? (rep_to ? '1 : cm_inc) : distance;
      timeout  <= rep ? rep_to : timeout;
    end
endmodule

// File: tb/tb_ultrasonido_ranger.sv
// tb_ultrasonido_ranger: randomized echo widths checked against a centimetre model
module tb_ultrasonido_ranger;
  localparam int TRIG = 4, CM = 10, TO = 200, HO = 50, DW = 4;
  localparam int SAT = (1 << DW) - 1;

  logic CLKOUT2 = 1'b0, reset = 1'b0, ENABLE = 1'b0, echo = 1'b0;
  logic trigger, valid, timeout, busy;
  logic [DW-1:0] distance;
  int checks = 0, errors = 0;
  int last_dist = 0, last_to = 0;

  ultrasonido_ranger #(
    .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO), .DIST_W(DW)
  ) dut (
    .CLKOUT2(CLKOUT2), .reset(reset), .ENABLE(ENABLE), .echo(echo),
    .trigger(trigger), .distance(distance), .valid(valid),
    .timeout(timeout), .busy(busy)
  );

  always #5 CLKOUT2 = ~CLKOUT2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_dist(input int w);
    return (w / CM > SAT) ? SAT : w / CM;
  endfunction

  task automatic step();
    @(posedge CLKOUT2);
    #1;
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (trigger !== 1'b1 && n < 1000) begin step(); n++; end
  endtask

  task automatic trig_pulse();
    int n, hi;
    wait_trig(n);
    hi = 0;
    while (trigger === 1'b1 && hi < 1000) begin hi++; step(); end
    check("trig_width", hi, TRIG);
    check("busy_run", busy, 1);
  endtask

  task automatic holdoff();
    int n;
    step();
    check("valid_single", valid, 0);
    n = 1;
    while (trigger !== 1'b1 && n < 1000) begin step(); n++; end
    check("holdoff", n, HO);
  endtask

  task automatic measure(input int d, input int w);
    int n, early;
    trig_pulse();
    early = 0;
    repeat (d) begin step(); if (valid) early++; end
    echo = 1'b1;
    repeat (w) begin step(); if (valid) early++; end
    echo = 1'b0;
    check("early_valid", early, 0);
    n = 0;
    while (valid !== 1'b1 && n < 1000) begin step(); n++; end
    check("valid_lat", n, 3);
    last_dist = model_dist(w);
    last_to = 0;
    check("dist", distance, last_dist);
    check("timeout_flag", timeout, 0);
    holdoff();
  endtask

  task automatic timeout_case(input logic stuck);
    int n;
    trig_pulse();
    echo = stuck;
    n = 0;
    while (valid !== 1'b1 && n < 1000) begin step(); n++; end
    echo = 1'b0;
    check(stuck ? "stuck_lat" : "noecho_lat", n, stuck ? TO + 3 : TO);
    last_dist = SAT;
    last_to = 1;
    check("to_dist", distance, SAT);
    check("to_flag", timeout, 1);
    holdoff();
  endtask

  initial begin
    int bad, vc;
    repeat (3) step();
    check("rst_trigger", trigger, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dist", distance, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      step();
      if (trigger || valid || busy || distance != 0) bad++;
    end
    check("idle_quiet", bad, 0);
    ENABLE = 1'b1;
    measure(20, 30);
    measure(7, 39);
    measure(3, 180);
    repeat (8) measure($urandom_range(0, 150), $urandom_range(2, 190));
    timeout_case(1'b0);
    timeout_case(1'b1);
    measure(10, 39);
    step();
    ENABLE = 1'b0;
    step();
    check("abort_trig_trigger", trigger, 0);
    check("abort_trig_busy", busy, 0);
    vc = 0;
    repeat (10) begin step(); if (valid || trigger) vc++; end
    check("abort_trig_quiet", vc, 0);
    check("abort_trig_dist", distance, last_dist);
    check("abort_trig_to", timeout, last_to);
    ENABLE = 1'b1;
    trig_pulse();
    echo = 1'b1;
    repeat (20) step();
    ENABLE = 1'b0;
    step();
    check("abort_meas_trigger", trigger, 0);
    check("abort_meas_busy", busy, 0);
    echo = 1'b0;
    vc = valid ? 1 : 0;
    repeat (10) begin step(); if (valid) vc++; end
    check("abort_meas_novalid", vc, 0);
    check("abort_meas_dist", distance, last_dist);
    check("abort_meas_to", timeout, last_to);
    ENABLE = 1'b1;
    trig_pulse();
    echo = 1'b1;
    repeat (20) step();
    reset = 1'b0;
    #1;
    check("arst_trigger", trigger, 0);
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_dist", distance, 0);
    check("arst_timeout", timeout, 0);
    ENABLE = 1'b0;
    echo = 1'b0;
    step();
    reset = 1'b1;
    repeat (5) step();
    check("post_rst_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ultrasonido_ranger.md
# ultrasonido_ranger

Trigger/echo engine for the HC-SR04 ultrasonic sensor, downstream of the ultrasonic enable state machine. While `ENABLE` is high it repeatedly fires a trigger pulse, times the returned echo pulse and reports the distance in whole centimetres with a one-cycle valid strobe. It handles a missing echo with a timeout, and a dropped `ENABLE` aborts any measurement in progress.

## Interface
- `TRIG_CYCLES`, 250: trigger pulse width in clocks (10 µs at 25 MHz).
- `CM_CYCLES`, 1450: clocks of echo-high per centimetre (58 µs at 25 MHz).
- `TIMEOUT_CYCLES`, 950000: maximum clocks spent waiting for echo rise, and separately for echo fall (38 ms).
- `HOLDOFF_CYCLES`, 1500000: idle gap after each measurement before the next trigger (60 ms).
- `DIST_W`, 9: width of the distance result.
- `CLKOUT2` in, 1: system clock. All logic runs on its rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `ENABLE` in, 1: synchronous run request from the enable state machine.
- `echo` in, 1: sensor echo pin, asynchronous to `CLKOUT2`.
- `trigger` out, 1: sensor trigger pin.
- `distance` out, `DIST_W`: last result in cm. Held until the next result.
- `valid` out, 1: single-cycle strobe, high when `distance`/`timeout` update.
- `timeout` out, 1: high when the last result was a timeout. Held with `distance`.
- `busy` out, 1: high in every state except IDLE.

## Operation
- `echo` passes through a 2-FF synchronizer, giving `echo_s`. All decisions use `echo_s`.
- State IDLE: `trigger`=0. If `ENABLE`=1, go to TRIG and clear the cycle counter.
- State TRIG: `trigger`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE.
- State WAIT_RISE: wait for `echo_s`=1, then go to MEASURE with the sub-counter and cm counter at 0.
  - If `TIMEOUT_CYCLES` elapse first, report a timeout.
- State MEASURE: the sub-counter counts 0..`CM_CYCLES`-1. Each wrap increments the cm counter.
  - The cm counter saturates at 2^`DIST_W`-1 and never wraps.
  - When `echo_s`=0, report `distance` = cm counter (truncated, no rounding), `timeout`=0.
  - If echo stays high for `TIMEOUT_CYCLES`, report a timeout.
- Reporting a timeout means `distance` = all ones and `timeout`=1.
- Any report pulses `valid` and moves to HOLDOFF.
- State HOLDOFF: wait `HOLDOFF_CYCLES`, then go to TRIG if `ENABLE`=1, else to IDLE.
- `ENABLE`=0 in any state: on the next edge go to IDLE.
  - Force `trigger`=0.
  - No `valid`; `distance`/`timeout` keep their old values.
- Echo already high in WAIT_RISE on the first cycle is accepted as a rise; no edge is required.
- Echo pulse narrower than 2 clocks may be missed. This is accepted behaviour.

## Timing
- Reset values: `trigger`=0, `distance`=0, `valid`=0, `timeout`=0, `busy`=0, state IDLE, synchronizer flops 0.
- All outputs are registered.
- `ENABLE` sampled high in IDLE at edge N: `trigger` is high from edge N+1 through edge N+`TRIG_CYCLES`, low from edge N+1+`TRIG_CYCLES`.
- Echo pin to `echo_s` latency: 2 cycles.
- `valid` goes high 1 cycle after `echo_s` is seen low in MEASURE, i.e. 3 cycles after the pin falls. `distance`/`timeout` update on that same edge.
- `valid` is never high two cycles in a row.
- Measurement cadence with `ENABLE` held high: the trigger period is `TRIG_CYCLES` + echo wait + echo width + 1 + `HOLDOFF_CYCLES` (approximate).
- `reset` asserted mid-measurement: all state clears immediately, asynchronously, with no `valid`.
- `ENABLE` falling in the same cycle a report would occur: abort wins, no `valid`.

## Test plan
Parameters for all scenarios: `TRIG_CYCLES`=4, `CM_CYCLES`=10, `TIMEOUT_CYCLES`=200, `HOLDOFF_CYCLES`=50, `DIST_W`=4.

- Reset and idle: `reset`=0 then 1, `ENABLE`=0 for 100 cycles -> `trigger`, `valid`, `busy` stay 0 and `distance`=0.
- Normal measurement: raise `ENABLE`; `trigger` high exactly 4 cycles; echo high 30 cycles after a 20-cycle delay -> one `valid`, `distance`=3, `timeout`=0, `valid` 3 cycles after echo falls.
- Truncation and saturation: echo 39 cycles -> `distance`=3; echo 180 cycles -> `distance`=15 (saturated), `timeout`=0.
- No echo: `ENABLE`=1, echo held 0 -> `valid` 200 cycles after entering WAIT_RISE with `distance`=15, `timeout`=1; next trigger follows after 50 holdoff cycles.
- Stuck echo: echo held 1 -> MEASURE timeout after 200 cycles, `distance`=15, `timeout`=1.
- Abort: drop `ENABLE` mid-TRIG and mid-MEASURE -> `trigger` 0 next cycle, `busy` 0, no `valid`, previous `distance` retained; also assert `reset` mid-MEASURE -> all outputs read reset values immediately.
